reg_bank_arbiter: RTL and testbench
===================================

Name: reg_bank_arbiter

Overview:
- Shares a bank of 32-bit registers among NUM_REQ write requesters using round-robin arbitration.
- Each register is a clock-only 32-bit register with no reset and no enable.
  - Write enable is built by feeding the selected register its old value back, or the granted new value.
  - Zero-at-reset is built by forcing the feedback value to 0 while rst is high.
- Sits between the datapath's write sources (ALU result, load unit, immediate path, ...) and the register bank.
- Provides one asynchronous read port for operand fetch.

Parameters:
- NUM_REQ, 4, number of write requesters; must be at least 2.
- DATA_W, 32, register width.
- ADDR_W, 3, register index width; bank depth NUM_REGS = 2**ADDR_W (localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock for all state and all bank registers.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester write request; bit i is requester i.
- req_addr  in  NUM_REQ*ADDR_W  target register; slice i is [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  write data; slice i is [i*DATA_W +: DATA_W].
- gnt  out  NUM_REQ  one-hot grant/ack; one-cycle pulse.
- busy  out  1  high while a write is in flight (state WRITE).
- rd_addr  in  ADDR_W  read index.
- rd_data  out  DATA_W  combinational read of bank[rd_addr].

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, rr_ptr=0, gnt=0, busy=0, latched addr/data=0.
  - All NUM_REGS bank registers read 0 from the first edge after rst rises.
- FSM, two states:
  - IDLE: if any req bit is set, the winner is the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
    - At the clk edge, latch win_id, req_addr[win_id] and req_data[win_id].
    - Set rr_ptr=(win_id+1) mod NUM_REQ; go to WRITE.
    - If no req bit is set, stay in IDLE; rr_ptr unchanged.
  - WRITE: busy=1 and gnt[win_id]=1 for exactly this cycle.
    - At the clk edge, the latched data is written to bank[latched addr]; go to IDLE unconditionally.
- Latency:
  - req sampled at edge N; gnt high during cycle N..N+1; data written at edge N+1.
  - rd_data shows the new value from edge N+1.
  - Peak throughput is one write per 2 cycles.
- Handshake:
  - A requester holds req/addr/data stable until it sees gnt.
  - Values are captured at the IDLE edge, so changing or dropping req during the gnt cycle does not affect the write in flight.
  - A req still high after its gnt cycle is a new request; it is arbitrated normally behind the other pending requesters.
- Fairness: with all NUM_REQ requesting continuously, grants rotate 0,1,...,NUM_REQ-1,0.
- Same target address from different requesters: writes serialize in grant order; the last writer wins.
- Reads:
  - rd_data is purely combinational from bank state.
  - During WRITE, rd_data for the target address returns the old value, unless the optional feature below is enabled.
- Reset mid-WRITE: the write is abandoned, gnt drops immediately, and the bank clears to 0.
- Bank registers not addressed keep their value every cycle.

Optional Feature:
- Macro: REG_WR_BYPASS_EN.
- Defined: in WRITE, if rd_addr equals the latched addr, rd_data returns the latched data (same-cycle forwarding); otherwise it returns bank[rd_addr].
- Undefined: no forwarding; the read returns the old value until the write edge.

Decomposition:
- Shared package holds:
  - localparams DATA_W=32 and ADDR_W=3;
  - state encodings ST_IDLE=1'b0 and ST_WRITE=1'b1;
  - the NUM_REGS derivation.
- One sub-module, reg_bank_we: NUM_REGS × DATA_W bank of the team's 32-bit clock-only register.
  - Per-register next value is 0 when rst is high, else wdata when we and waddr match, else the current value (feedback mux).
  - Outputs a flat bank vector.
- reg_bank_arbiter contains the FSM, round-robin pointer, latch and read mux.

Test Plan:
- Reset then idle: hold rst 2 cycles, release, req=0 for 5 cycles -> gnt=0, busy=0, rd_data=0 for all 8 rd_addr.
- Single write: req=4'b0100, addr2=5, data2=32'hDEADBEEF -> gnt=4'b0100 one cycle after the sampling edge; rd_addr=5 reads DEADBEEF from the next edge; other registers stay 0.
- Round robin: req=4'b1111 held 8 writes, requester i writing i+1 to addr i -> gnt order 0,1,2,3,0,1,2,3; bank[0..3]=1,2,3,4.
- Address collision: req0 and req1 both target addr 7 with 32'h11 and 32'h22 -> grant 0 then 1; final bank[7]=32'h22.
- Reset mid-WRITE: assert rst during the gnt cycle of a write of 32'hFFFF to addr 3 -> gnt drops at once; bank[3]=0 after release; next grant goes to requester 0.
- Bypass: write 32'hA5A5A5A5 to addr 1 with rd_addr=1 -> in the gnt cycle rd_data=A5A5A5A5 with REG_WR_BYPASS_EN defined, and the old value (0) without it.

Source files
------------

// File: rtl/reg_bank_arbiter_pkg.sv
// Shared constants, FSM encoding and bank-depth helper for the register-bank arbiter.
// No logic, so there is no latency.
// No backpressure applies here.
package reg_bank_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

    function automatic int calc_num_regs(input int addr_w);
        return 1 << addr_w;
    endfunction

    localparam int NUM_REGS = calc_num_regs(ADDR_W);

endpackage

// File: rtl/reg_bank_arbiter_we.sv
// Register bank built from clock-only registers, using a feedback mux for enable and clear.
// Writes land on the clk edge where we is high; the bank is cleared on any edge while rst is high.
// No backpressure: every write presented is taken.
module reg_bank_we #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                we,
    input  logic [ADDR_W-1:0]                   waddr,
    input  logic [DATA_W-1:0]                   wdata,
    output logic [(1 << ADDR_W)*DATA_W-1:0]     bank
);
    import reg_bank_arbiter_pkg::*;

    localparam int NUM_REGS = calc_num_regs(ADDR_W);

    logic [DATA_W-1:0] bank_q [NUM_REGS];
    logic [DATA_W-1:0] bank_d [NUM_REGS];

    // The registers have no reset or enable pins, so both are folded into the D-side mux.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            bank_d[i] = bank_q[i];
            if (rst) begin
                bank_d[i] = '0;
            end else if (we && (waddr == ADDR_W'(i))) begin
                bank_d[i] = wdata;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        always_ff @(posedge clk) begin
            bank_q[g] <= bank_d[g];
        end
    end

    always_comb begin
        bank = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            bank[i*DATA_W +: DATA_W] = bank_q[i];
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin write arbiter in front of the register bank, with one async read port. Optional macro: REG_WR_BYPASS_EN.
// The request is sampled at edge N, gnt is high for cycle N..N+1, and the bank is written at edge N+1.
// A request is held until gnt; peak throughput is one write every two cycles.
module reg_bank_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = reg_bank_arbiter_pkg::DATA_W,
    parameter int ADDR_W  = reg_bank_arbiter_pkg::ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      busy,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [DATA_W-1:0]         rd_data
);
    import reg_bank_arbiter_pkg::*;

    localparam int NUM_REGS = calc_num_regs(ADDR_W);
    localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    win_q, win_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [NUM_REGS*DATA_W-1:0] bank_flat;
    logic [DATA_W-1:0]   bank_rd;
    logic                bank_we;

    // Searches for the first set request bit at or above ptr, wrapping at NUM_REQ.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [PTR_W-1:0]   ptr);
        logic [PTR_W-1:0] w;
        logic             hit;
        int               idx;
        w   = ptr;
        hit = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!hit && r[PTR_W'(idx)]) begin
                w   = PTR_W'(idx);
                hit = 1'b1;
            end
        end
        return w;
    endfunction

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        addr_d   = addr_q;
        data_d   = data_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    win_d    = rr_pick(req, rr_ptr_q);
                    addr_d   = req_addr[int'(win_d)*ADDR_W +: ADDR_W];
                    data_d   = req_data[int'(win_d)*DATA_W +: DATA_W];
                    rr_ptr_d = PTR_W'((int'(win_d) + 1) % NUM_REQ);
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    // gnt and busy decode straight from state, so an async reset drops them without waiting for an edge.
    always_comb begin
        gnt  = '0;
        busy = (state_q == ST_WRITE);
        if (state_q == ST_WRITE) begin
            gnt[win_q] = 1'b1;
        end
    end

    assign bank_we = (state_q == ST_WRITE);

    reg_bank_we #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (bank_we),
        .waddr (addr_q),
        .wdata (data_q),
        .bank  (bank_flat)
    );

    assign bank_rd = bank_flat[int'(rd_addr)*DATA_W +: DATA_W];

`ifdef REG_WR_BYPASS_EN
    // Forward the in-flight write so operand fetch sees it one cycle early.
    assign rd_data = ((state_q == ST_WRITE) && (rd_addr == addr_q)) ? data_q : bank_rd;
`else
    assign rd_data = bank_rd;
`endif

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed plus randomized bench for reg_bank_arbiter against a transaction-level reference model.
module tb_reg_bank_arbiter;
    localparam int NR    = 4;
    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int NREGS = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   gnt;
    logic            busy;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_data;

    int n_tests = 0;
    int n_fail  = 0;
    int last_win;

    logic [DW-1:0] ref_bank [NREGS];
    int            ref_ptr;

    always #5 clk = ~clk;

    reg_bank_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .gnt      (gnt),
        .busy     (busy),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [NR-1:0] r);
        logic [NR-1:0] rot;
        int            j;
        for (int k = 0; k < NR; k++) begin
            j   = (ref_ptr + k) % NR;
            rot = r >> j;
            if (rot[0]) return j;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) ref_bank[i] = '0;
        ref_ptr = 0;
    endtask

    // One arbitration round: the sampling edge, the gnt cycle, then the write edge.
    task automatic step(input bit drop, input string tag);
        int            w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_rd;
        w = model_pick(req);
        if (w < 0) begin
            @(posedge clk); #1;
            check({tag, " idle gnt"}, DW'(gnt), '0);
            check({tag, " idle busy"}, DW'(busy), '0);
            return;
        end
        a = req_addr[w*AW +: AW];
        d = req_data[w*DW +: DW];
        @(posedge clk); #1;
        ref_ptr  = (w + 1) % NR;
        last_win = w;
        check({tag, " gnt"}, DW'(gnt), DW'(1) << w);
        check({tag, " busy"}, DW'(busy), DW'(1));
        rd_addr = a; #1;
`ifdef REG_WR_BYPASS_EN
        exp_rd = d;
`else
        exp_rd = ref_bank[a];
`endif
        check({tag, " rd in gnt cycle"}, rd_data, exp_rd);
        ref_bank[a] = d;
        if (drop) begin
            req[w] = 1'b0;
            req_data[w*DW +: DW] = $urandom();
        end
        @(posedge clk); #1;
        check({tag, " gnt after write"}, DW'(gnt), '0);
        check({tag, " rd after write"}, rd_data, ref_bank[a]);
        rd_addr = AW'($urandom_range(0, NREGS-1)); #1;
        check({tag, " rd random"}, rd_data, ref_bank[rd_addr]);
    endtask

    initial begin
        rst = 1'b1; req = '0; req_addr = '0; req_data = '0; rd_addr = '0;
        last_win = -1;
        model_reset();

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        check("reset gnt", DW'(gnt), '0);
        check("reset busy", DW'(busy), '0);
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            check("idle gnt", DW'(gnt), '0);
            check("idle busy", DW'(busy), '0);
        end
        for (int i = 0; i < NREGS; i++) begin
            rd_addr = AW'(i); #1;
            check("reset bank", rd_data, '0);
        end

        // Round robin with all four held
        for (int i = 0; i < NR; i++) set_req(i, AW'(i), DW'(i + 1));
        req = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            step(1'b0, "rr");
            check("rr order", DW'(last_win), DW'(n % NR));
        end
        req = '0;
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) begin
            rd_addr = AW'(i); #1;
            check("rr bank", rd_data, DW'(i + 1));
        end

        // Single write from requester 2
        set_req(2, 3'd5, 32'hDEADBEEF);
        req = 4'b0100;
        step(1'b1, "single");
        check("single winner", DW'(last_win), DW'(2));
        @(posedge clk); #1;
        rd_addr = 3'd5; #1;
        check("single rd5", rd_data, 32'hDEADBEEF);
        rd_addr = 3'd6; #1;
        check("single rd6", rd_data, '0);

        // Address collision, last writer wins
        set_req(0, 3'd7, 32'h11);
        set_req(1, 3'd7, 32'h22);
        req = 4'b0011;
        step(1'b1, "coll");
        check("coll first", DW'(last_win), DW'(0));
        step(1'b1, "coll");
        check("coll second", DW'(last_win), DW'(1));
        rd_addr = 3'd7; #1;
        check("coll final", rd_data, 32'h22);

        // Reset during the gnt cycle
        set_req(2, 3'd3, 32'hFFFF);
        req = 4'b0100;
        @(posedge clk); #1;
        check("midrst gnt before", DW'(gnt), DW'(4'b0100));
        rst = 1'b1; #1;
        check("midrst gnt drop", DW'(gnt), '0);
        check("midrst busy drop", DW'(busy), '0);
        req = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        rd_addr = 3'd3; #1;
        check("midrst bank3", rd_data, '0);
        rd_addr = 3'd7; #1;
        check("midrst bank7", rd_data, '0);
        set_req(0, 3'd0, 32'h1000);
        set_req(2, 3'd2, 32'h1002);
        set_req(3, 3'd4, 32'h1003);
        req = 4'b1101;
        step(1'b1, "postrst");
        check("postrst winner", DW'(last_win), DW'(0));
        step(1'b1, "postrst");
        step(1'b1, "postrst");

        // Same-cycle read of the write target
        set_req(1, 3'd1, 32'hA5A5A5A5);
        req = 4'b0010;
        step(1'b1, "bypass");
        check("bypass winner", DW'(last_win), DW'(1));

        // Randomized traffic; pending requesters keep their addr/data stable
        for (int t = 0; t < 150; t++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req[i] && ($urandom_range(0, 1) == 1)) begin
                    set_req(i, AW'($urandom_range(0, NREGS-1)), $urandom());
                    req[i] = 1'b1;
                end
            end
            step(1'b1, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
